// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR stream run sequencer.
// Holds the run-state encoding and the latency clamp helper.
package fir_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int SNK_W_DEF  = 32;
  localparam int TV_W_DEF   = 64;
  localparam int LEN_W_DEF  = 20;
  localparam int MAX_LAT    = 64;
  localparam int LAT_W      = 7;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  // Limit a requested latency to the delay-line depth.
  function automatic logic [LAT_W-1:0] clamp_lat(
    input logic [LAT_W-1:0] lat,
    input int               max_lat
  );
    if (int'(lat) > max_lat)
      return LAT_W'(max_lat);
    return lat;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Shift register of strobe bits with a runtime tap select.
// Tap 0 passes the input straight through; tap k gives a k-cycle delay.
module valid_delay_line #(
  parameter int DEPTH = fir_seq_pkg::MAX_LAT,
  parameter int TAP_W = fir_seq_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_din,
  input  logic [TAP_W-1:0] i_tap,
  output logic             o_dout
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_sh;
  logic [IW-1:0]    w_idx;

  assign w_idx = IW'(i_tap - TAP_W'(1));

  // Shift the strobe history; a clear empties every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sh <= '0;
    else if (i_clr)
      r_sh <= '0;
    else
      r_sh <= {r_sh[DEPTH-2:0], i_din};
  end

  // Select the requested delay, saturating at the deepest stage.
  always_comb begin
    o_dout = i_din;
    if (i_tap != '0) begin
      if (int'(i_tap) > DEPTH)
        o_dout = r_sh[DEPTH-1];
      else
        o_dout = r_sh[w_idx];
    end
  end

endmodule

// File: rtl/fir_stream_sequencer.sv
// Run controller feeding cfg_len samples into the FIR DUT and
// capturing the matching outputs/testvecs into two sink streams.
module fir_stream_sequencer #(
  parameter int DATA_W  = fir_seq_pkg::DATA_W_DEF,
  parameter int SNK_W   = fir_seq_pkg::SNK_W_DEF,
  parameter int TV_W    = fir_seq_pkg::TV_W_DEF,
  parameter int LEN_W   = fir_seq_pkg::LEN_W_DEF,
  parameter int MAX_LAT = fir_seq_pkg::MAX_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [6:0]           cfg_latency,
  input  logic [SNK_W-1:0]     src_tdata,
  input  logic                 src_tvalid,
  output logic                 src_tready,
  output logic [DATA_W-1:0]    dut_data_in,
  input  logic [DATA_W-1:0]    dut_data_out,
  input  logic [TV_W-1:0]      dut_testvec,
  output logic [SNK_W-1:0]     snk_tdata,
  output logic [SNK_W/8-1:0]   snk_tkeep,
  output logic                 snk_tvalid,
  output logic                 snk_tlast,
  input  logic                 snk_tready,
  output logic [TV_W-1:0]      tv_tdata,
  output logic [TV_W/8-1:0]    tv_tkeep,
  output logic                 tv_tvalid,
  output logic                 tv_tlast,
  input  logic                 tv_tready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [LEN_W-1:0]     drop_cnt
);

  import fir_seq_pkg::*;

  seq_state_t        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_in_cnt;
  logic [LEN_W-1:0]  r_out_cnt;
  logic [LEN_W-1:0]  r_drop_cnt;
  logic [6:0]        r_lat;
  logic              r_src_tready;
  logic              r_acc;
  logic              r_done;
  logic              r_overrun;
  logic [DATA_W-1:0] r_din;
  logic [SNK_W-1:0]  r_snk_data;
  logic              r_snk_valid;
  logic              r_snk_last;
  logic [TV_W-1:0]   r_tv_data;
  logic              r_tv_valid;
  logic              r_tv_last;

  logic w_accept;
  logic w_start;
  logic w_clr;
  logic w_cap;
  logic w_snk_free;
  logic w_tv_free;
  logic w_load;
  logic w_drop;
  logic w_last;
  logic w_unused;

  assign w_accept   = src_tvalid & r_src_tready;
  assign w_start    = cfg_start & (r_state == IDLE) & ~cfg_abort;
  assign w_clr      = cfg_abort | w_start;
  assign w_snk_free = ~r_snk_valid | snk_tready;
  assign w_tv_free  = ~r_tv_valid | tv_tready;
  assign w_load     = w_cap & w_snk_free & w_tv_free;
  assign w_drop     = w_cap & ~w_load;
  assign w_last     = (r_out_cnt + LEN_W'(1)) == r_len;
  assign w_unused   = ^src_tdata[SNK_W-1:DATA_W];

  valid_delay_line #(
    .DEPTH (MAX_LAT),
    .TAP_W (7)
  ) u_cap_dly (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_din  (r_acc),
    .i_tap  (r_lat),
    .o_dout (w_cap)
  );

  // Run FSM: feed samples, count accepts/captures, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_lat        <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_src_tready <= 1'b0;
      r_acc        <= 1'b0;
      r_din        <= '0;
      r_done       <= 1'b0;
    end else if (cfg_abort) begin
      r_state      <= IDLE;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_src_tready <= 1'b0;
      r_acc        <= 1'b0;
      r_din        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_acc  <= w_accept;
      r_din  <= w_accept ? src_tdata[DATA_W-1:0] : '0;
      if (w_cap)
        r_out_cnt <= r_out_cnt + LEN_W'(1);
      unique case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_len     <= cfg_len;
            r_lat     <= clamp_lat(cfg_latency, MAX_LAT);
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            if (cfg_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= FEED;
              r_src_tready <= 1'b1;
            end
          end
        end
        FEED: begin
          if (w_accept) begin
            r_in_cnt <= r_in_cnt + LEN_W'(1);
            if ((r_in_cnt + LEN_W'(1)) == r_len) begin
              r_state      <= DRAIN;
              r_src_tready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (r_out_cnt == r_len && w_snk_free && w_tv_free) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output registers: load on capture, drop when blocked, flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snk_data  <= '0;
      r_snk_valid <= 1'b0;
      r_snk_last  <= 1'b0;
      r_tv_data   <= '0;
      r_tv_valid  <= 1'b0;
      r_tv_last   <= 1'b0;
      r_overrun   <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (cfg_abort) begin
      r_snk_valid <= 1'b0;
      r_snk_last  <= 1'b0;
      r_tv_valid  <= 1'b0;
      r_tv_last   <= 1'b0;
    end else begin
      if (w_start) begin
        r_overrun  <= 1'b0;
        r_drop_cnt <= '0;
      end
      if (r_snk_valid && snk_tready) begin
        r_snk_valid <= 1'b0;
        r_snk_last  <= 1'b0;
      end
      if (r_tv_valid && tv_tready) begin
        r_tv_valid <= 1'b0;
        r_tv_last  <= 1'b0;
      end
      if (w_load) begin
        r_snk_data  <= SNK_W'(dut_data_out);
        r_snk_valid <= 1'b1;
        r_snk_last  <= w_last;
        r_tv_data   <= dut_testvec;
        r_tv_valid  <= 1'b1;
        r_tv_last   <= w_last;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (~&r_drop_cnt)
          r_drop_cnt <= r_drop_cnt + LEN_W'(1);
        if (w_last) begin
          if (r_snk_valid && !snk_tready)
            r_snk_last <= 1'b1;
          if (r_tv_valid && !tv_tready)
            r_tv_last <= 1'b1;
        end
      end
    end
  end

  assign src_tready  = r_src_tready;
  assign dut_data_in = r_din;
  assign snk_tdata   = r_snk_data;
  assign snk_tkeep   = '1;
  assign snk_tvalid  = r_snk_valid;
  assign snk_tlast   = r_snk_last;
  assign tv_tdata    = r_tv_data;
  assign tv_tkeep    = '1;
  assign tv_tvalid   = r_tv_valid;
  assign tv_tlast    = r_tv_last;
  assign busy        = (r_state == FEED) || (r_state == DRAIN);
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: doc/fir_stream_sequencer.md
Name: fir_stream_sequencer

Overview:
- Run controller between the DMA stream endpoints and the DUT (`fir_top`) in the PCIe/DDR4 test harness.
- Replaces the static stream tie-offs (tvalid=1, tready=1, tlast=0).
- Per run: feeds exactly `cfg_len` source samples into the DUT and tracks the DUT pipeline latency.
- Captures the matching `cfg_len` output and testvec beats into the sink streams, with a proper `tlast` and overrun detection.

Parameters:
- DATA_W, 16, DUT sample width.
- SNK_W, 32, sink/source stream data width.
- TV_W, 64, testvec stream width.
- LEN_W, 20, run-length counter width.
- MAX_LAT, 64, maximum supported DUT latency in cycles (delay-line depth).

Ports:
- clk  in  1  Harness clock (`tb_clk`).
- rst  in  1  Asynchronous, active-high reset.
- cfg_start  in  1  Single-cycle pulse; starts a run.
- cfg_abort  in  1  Level; terminates the run immediately.
- cfg_len  in  LEN_W  Samples per run; sampled on start.
- cfg_latency  in  7  DUT latency L; sampled on start, clamped to MAX_LAT.
- src_tdata  in  SNK_W  Source stream data; bits [DATA_W-1:0] are used.
- src_tvalid  in  1  Source stream valid.
- src_tready  out  1  Source stream ready.
- dut_data_in  out  DATA_W  Registered sample to the DUT.
- dut_data_out  in  DATA_W  DUT output.
- dut_testvec  in  TV_W  DUT test vector.
- snk_tdata  out  SNK_W  Sink data: zero-extended `dut_data_out`.
- snk_tkeep  out  SNK_W/8  Sink keep; all ones.
- snk_tvalid, snk_tlast  out  1 each  Sink valid / last.
- snk_tready  in  1  Sink ready.
- tv_tdata  out  TV_W  Testvec stream data.
- tv_tkeep  out  TV_W/8  Testvec keep; all ones.
- tv_tvalid, tv_tlast  out  1 each  Testvec valid / last.
- tv_tready  in  1  Testvec ready.
- busy  out  1  High in FEED or DRAIN.
- done  out  1  One-cycle pulse at end of a completed run.
- overrun  out  1  Sticky drop flag; cleared on start.
- drop_cnt  out  LEN_W  Dropped-beat count; cleared on start.

Behaviour:
- Reset: every output is 0 except the tkeep ports, which are all ones. State=IDLE; delay line cleared.

States and transitions:
- IDLE
  - `cfg_start` with `cfg_len`≠0 → FEED.
  - `cfg_start` with `cfg_len`=0 → DONE, with no beats emitted.
- FEED
  - `src_tready`=1.
  - On accept (`src_tvalid` & `src_tready`) at cycle t: `dut_data_in` ← `src_tdata[DATA_W-1:0]` at t+1. With no accept, `dut_data_in` ← 0 (zero-stuff).
  - `in_cnt` increments per accept. At the `cfg_len`-th accept, `src_tready` drops the next cycle → DRAIN.
- DRAIN
  - `src_tready`=0 and `dut_data_in`=0.
  - → DONE when `out_cnt`==`cfg_len` and both sink registers are empty.
- DONE: `done`=1 for one cycle → IDLE.
- `cfg_start` while busy or in DONE is ignored.

Capture:
- Delay line: bit set at t+1 for an accept at t; it emerges as `cap_en` at cycle t+1+L.
- On `cap_en`: if both output registers are empty, or being emptied this cycle, load `snk_tdata` and `tv_tdata` and set both tvalid at t+2+L. `out_cnt` increments.
- Otherwise the beat is dropped: `drop_cnt`++, `overrun`←1, `out_cnt` still increments.
- Each channel clears its own tvalid on its own handshake.
- `tlast`=1 on the beat carrying `out_cnt`==`cfg_len`.
- If that final beat is dropped, `tlast` is forced to 1 on the beat currently held in each channel.

Abort:
- Any state → IDLE on the next edge.
- tvalid, `src_tready` and `busy` deassert; delay line and counters clear.
- No `tlast` and no `done`.
- `overrun`/`drop_cnt` hold their values.

Widths:
- Counters are LEN_W bits and never wrap within a run, since `cfg_len` ≤ 2^LEN_W−1.
- `drop_cnt` saturates at all-ones.
- L=0 is legal: `cap_en` fires the same cycle the sample reaches the DUT.

Decomposition:
- Package `fir_seq_pkg`: state enum (IDLE, FEED, DRAIN, DONE), default widths, `MAX_LAT`.
- Sub-module `valid_delay_line`: MAX_LAT-deep shift register of valid bits with a runtime tap select (`cfg_latency`) and synchronous clear. Reused for any delayed strobe.

Test Plan:
1. `cfg_len`=8, L=3, `src_tvalid`=1, readies=1 → 8 sink beats on consecutive cycles; the first appears 5 cycles after the first accept; `tlast` on beat 8; `done` 1 cycle later; `drop_cnt`=0.
2. `cfg_len`=4, L=0, `src_tvalid` toggling 1010… → DUT sees 0 between samples; 4 sink beats match the inputs; `tlast` on beat 4.
3. `cfg_len`=6, L=2, `snk_tready` low for 3 cycles mid-run → `overrun`=1, `drop_cnt`=2, final held beat has `tlast`=1, `done` asserted.
4. `cfg_len`=100, `cfg_abort` at accept 40 → next cycle: `busy`=0, tvalid=0, no `tlast`, no `done`; a new start at `cfg_len`=2 completes normally.
5. `cfg_len`=0 start → `done` pulse 1 cycle later, zero beats; `cfg_start` during a busy run → ignored, beat count unchanged.
6. `cfg_latency`=100 (>MAX_LAT=64) → capture uses L=64; reset asserted mid-run → all outputs 0 immediately.
